shift_reg_univ: RTL and testbench

Parametrised universal shift register: the next generation of the team's fixed 4-bit left-shift register. It keeps single-cycle serial shifting and adds parallel load, both shift directions, rotate, arithmetic right shift and clear. A burst command shifts the register by a programmed count, one bit per cycle, with busy/done status. It sits in serial-to-parallel and parallel-to-serial datapaths where a controller issues shift bursts and polls or waits on a completion pulse.

---
 rtl/shift_reg_univ.sv | 114 +++++++++++
 tb/tb_shift_reg_univ.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, shift/rotate in both directions,
// arithmetic right shift and clear, plus a counted burst mode that shifts one
// bit per cycle and reports busy/done.
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             shout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ROL  = 3'd3;
  localparam logic [2:0] M_ROR  = 3'd4;
  localparam logic [2:0] M_LOAD = 3'd5;
  localparam logic [2:0] M_ASR  = 3'd6;
  localparam logic [2:0] M_CLR  = 3'd7;

  localparam logic [CNT_W-1:0] REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] REM_ZERO = '0;

  logic [0:0]       state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] rem;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_sh;
  logic             mode_shifts;

  // During a burst the latched op drives the datapath; otherwise the live mode.
  always_comb op_sel = (state == SHIFT) ? op_q : mode;

  // Only ops that move bits out of the register are worth a burst.
  always_comb mode_shifts = (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
                            (mode == M_ROR) || (mode == M_ASR);

  // Next register value and shifted-out bit for the selected op; hold, load
  // and clear keep the previous shout.
  always_comb begin
    nxt_out = out;
    nxt_sh  = shout;
    case (op_sel)
      M_SHL:  begin nxt_out = {out[WIDTH-2:0], sin_r};       nxt_sh = out[WIDTH-1]; end
      M_SHR:  begin nxt_out = {sin_l, out[WIDTH-1:1]};       nxt_sh = out[0];       end
      M_ROL:  begin nxt_out = {out[WIDTH-2:0], out[WIDTH-1]}; nxt_sh = out[WIDTH-1]; end
      M_ROR:  begin nxt_out = {out[0], out[WIDTH-1:1]};      nxt_sh = out[0];       end
      M_ASR:  begin nxt_out = {out[WIDTH-1], out[WIDTH-1:1]}; nxt_sh = out[0];      end
      M_LOAD: nxt_out = d;
      M_CLR:  nxt_out = '0;
      M_HOLD: nxt_out = out;
      default: nxt_out = out;
    endcase
  end

  // Control FSM and datapath registers; start outranks single-step in IDLE,
  // and all inputs except the serial bits are ignored while shifting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      out   <= '0;
      shout <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_q  <= M_HOLD;
      rem   <= REM_ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_shifts && (count != REM_ZERO)) begin
              op_q  <= mode;
              rem   <= count;
              busy  <= 1'b1;
              state <= SHIFT;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            out   <= nxt_out;
            shout <= nxt_sh;
          end
        end
        default: begin
          out   <= nxt_out;
          shout <= nxt_sh;
          rem   <= rem - REM_ONE;
          if (rem == REM_ONE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios with fixed expectations, then
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_shift_reg_univ;
  localparam int W  = 8;
  localparam int CW = 4;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR  = 3'd4, LOAD = 3'd5, ASR = 3'd6, CLR = 3'd7;

  logic          clk, rst, en, sin_r, sin_l, start;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] count;
  logic [W-1:0]  out;
  logic          shout, busy, done;

  int checks = 0;
  int failures = 0;

  shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
    .d(d), .start(start), .count(count), .out(out), .shout(shout),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register value as an integer, burst as "shifts left".
  int       m_out, m_sh, m_left, m_done;
  logic [2:0] m_op;

  function automatic bit is_shift(input logic [2:0] m);
    return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR) || (m == ASR);
  endfunction

  // Returns shout*2^W + new value, computed with plain arithmetic.
  function automatic int apply(input logic [2:0] m, input int v, input int sl,
                               input int sr, input int dd, input int sh);
    int p, top, lsb;
    p = 2 ** W;
    top = v / (p / 2);
    lsb = v % 2;
    case (m)
      SHL:  return top * p + (v * 2 + sr) % p;
      SHR:  return lsb * p + v / 2 + sl * (p / 2);
      ROL:  return top * p + (v * 2 + top) % p;
      ROR:  return lsb * p + v / 2 + lsb * (p / 2);
      ASR:  return lsb * p + v / 2 + top * (p / 2);
      LOAD: return sh * p + dd;
      CLR:  return sh * p;
      default: return sh * p + v;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    int r;
    if (!rst) begin
      m_out <= 0; m_sh <= 0; m_left <= 0; m_done <= 0; m_op <= HOLD;
    end else begin
      m_done <= 0;
      if (m_left > 0) begin
        r = apply(m_op, m_out, int'(sin_l), int'(sin_r), int'(d), m_sh);
        m_out <= r % (2 ** W);
        m_sh  <= r / (2 ** W);
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1;
      end else if (start) begin
        if (is_shift(mode) && count != 0) begin
          m_op <= mode;
          m_left <= int'(count);
        end else begin
          m_done <= 1;
        end
      end else if (en) begin
        r = apply(mode, m_out, int'(sin_l), int'(sin_r), int'(d), m_sh);
        m_out <= r % (2 ** W);
        m_sh  <= r / (2 ** W);
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("out", int'(out), m_out);
    chk("shout", int'(shout), m_sh);
    chk("busy", int'(busy), int'(m_left > 0));
    chk("done", int'(done), m_done);
  endtask

  // Drive one cycle's inputs at the falling edge, clock once, compare model.
  task automatic step(input logic e, input logic [2:0] m, input logic sr,
                      input logic sl, input logic [W-1:0] dd, input logic st,
                      input logic [CW-1:0] c);
    en = e; mode = m; sin_r = sr; sin_l = sl; d = dd; start = st; count = c;
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b0; en = 1'b0; mode = HOLD; sin_r = 1'b0; sin_l = 1'b0;
    d = '0; start = 1'b0; count = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_shout", int'(shout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;

    // Single-step ops
    step(1, LOAD, 0, 0, 8'hA5, 0, 0); chk("ld_a5", int'(out), 'hA5);
    step(1, SHL, 1, 0, 8'h00, 0, 0);  chk("shl", int'(out), 'h4B); chk("shl_sh", int'(shout), 1);
    step(1, ASR, 0, 0, 8'h00, 0, 0);  chk("asr", int'(out), 'h25); chk("asr_sh", int'(shout), 1);
    step(1, CLR, 0, 0, 8'h00, 0, 0);  chk("clr", int'(out), 0);
    step(0, LOAD, 0, 0, 8'hFF, 0, 0); chk("en0_hold", int'(out), 0);

    // Rotates
    step(1, LOAD, 0, 0, 8'h81, 0, 0);
    step(1, ROL, 0, 0, 8'h00, 0, 0);  chk("rol", int'(out), 'h03); chk("rol_sh", int'(shout), 1);
    step(1, ROR, 0, 0, 8'h00, 0, 0);
    step(1, ROR, 0, 0, 8'h00, 0, 0);  chk("ror2", int'(out), 'hC0); chk("ror_sh", int'(shout), 1);

    // Burst SHL x7
    step(1, LOAD, 0, 0, 8'h01, 0, 0);
    step(1, SHL, 0, 0, 8'h00, 1, 4'd7);
    chk("bst_busy0", int'(busy), 1);
    busy_cycles = int'(busy);
    for (int i = 0; i < 7; i++) begin
      step(0, HOLD, 0, 0, 8'h00, 0, 0);
      busy_cycles += int'(busy);
      if (i < 6) chk("bst_nodone", int'(done), 0);
    end
    chk("bst_out", int'(out), 'h80);
    chk("bst_done", int'(done), 1);
    chk("bst_busy_cycles", busy_cycles, 7);
    step(0, HOLD, 0, 0, 8'h00, 0, 0); chk("bst_done_drop", int'(done), 0);

    // Inputs ignored during a burst
    step(1, LOAD, 0, 0, 8'h0F, 0, 0);
    step(0, ROR, 0, 0, 8'h00, 1, 4'd4);
    step(1, LOAD, 0, 0, 8'hFF, 1, 4'd1);
    step(1, LOAD, 0, 0, 8'hFF, 1, 4'd1);
    step(0, HOLD, 0, 0, 8'h00, 0, 0);
    chk("ign_busy", int'(busy), 1);
    step(0, HOLD, 0, 0, 8'h00, 0, 0);
    chk("ign_out", int'(out), 'hF0); chk("ign_done", int'(done), 1);

    // Zero-count and non-shift bursts
    step(1, LOAD, 0, 0, 8'h3C, 0, 0);
    step(0, SHL, 1, 0, 8'h00, 1, 4'd0);
    chk("z_busy", int'(busy), 0); chk("z_done", int'(done), 1); chk("z_out", int'(out), 'h3C);
    step(0, HOLD, 0, 0, 8'h00, 0, 0); chk("z_drop", int'(done), 0);
    step(1, LOAD, 0, 0, 8'hFF, 1, 4'd5);
    chk("nl_busy", int'(busy), 0); chk("nl_done", int'(done), 1); chk("nl_out", int'(out), 'h3C);

    // Reset mid-burst
    step(1, LOAD, 0, 0, 8'h5A, 0, 0);
    step(0, SHR, 0, 1, 8'h00, 1, 4'd10);
    repeat (4) step(0, HOLD, 0, 1, 8'h00, 0, 0);
    rst = 1'b0;
    #1;
    chk("mr_out", int'(out), 0); chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0); chk("mr_shout", int'(shout), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, LOAD, 0, 0, 8'h77, 0, 0); chk("mr_load", int'(out), 'h77);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) != 0);
      step(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
